// File: rtl/minifpga_cfg_pkg.sv
// -----------------------------------------------------------------------------
// minifpga_cfg_pkg
// Shared types and constants for the MiniFPGA serial configuration loader.
//   state_t     : loader FSM states
//   PREAMBLE    : sync word that starts a bitstream
//   CRC_INIT    : CRC-16-CCITT seed
//   CRC_POLY    : CRC-16-CCITT polynomial
//   crc16_step  : one serial MSB-first CRC update
// -----------------------------------------------------------------------------
package minifpga_cfg_pkg;

   typedef enum logic [2:0] {
      HUNT  = 3'd0,
      HDR   = 3'd1,
      FRAME = 3'd2,
      WRITE = 3'd3,
      CRC   = 3'd4,
      DONE  = 3'd5,
      ERR   = 3'd6
   } state_t;

   localparam logic [15:0] PREAMBLE = 16'h7EAA;
   localparam logic [15:0] CRC_INIT = 16'hFFFF;
   localparam logic [15:0] CRC_POLY = 16'h1021;

   function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic b);
      logic fb;
      fb = crc[15] ^ b;
      return {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
   endfunction

endpackage

// File: rtl/minifpga_cfg_loader_crc16.sv
// -----------------------------------------------------------------------------
// minifpga_crc16
// Serial CRC-16-CCITT accumulator, one bit per enabled cycle, MSB first.
// Ports:
//   i_clk     clock, rising edge
//   i_resetb  asynchronous active-low reset
//   i_init    load CRC_INIT (has priority over i_en)
//   i_en      fold i_bit_in into the running CRC
//   i_bit_in  serial data bit
//   o_crc     current CRC value
// -----------------------------------------------------------------------------
module minifpga_crc16
   import minifpga_cfg_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_resetb,
   input  logic        i_init,
   input  logic        i_en,
   input  logic        i_bit_in,
   output logic [15:0] o_crc
);

   logic [15:0] r_crc;

   always_ff @(posedge i_clk or negedge i_resetb) begin
      if (!i_resetb)   r_crc <= CRC_INIT;
      else if (i_init) r_crc <= CRC_INIT;
      else if (i_en)   r_crc <= crc16_step(r_crc, i_bit_in);
   end

   assign o_crc = r_crc;

endmodule

// File: rtl/minifpga_cfg_loader.sv
// -----------------------------------------------------------------------------
// minifpga_cfg_loader
// Bit-serial configuration receiver: hunts for the preamble, reads a frame
// count, shifts in address/data frames and writes them to config memory,
// then (optionally) checks a trailing CRC and flags DONE or ERROR.
// Optional feature macro: MINIFPGA_CFG_CRC_EN (CRC field + ERROR present).
// Ports:
//   i_clk, i_resetb           clock / asynchronous active-low reset
//   i_clear                   synchronous restart to HUNT, clears DONE/ERROR
//   i_sdi, i_svalid, o_sready serial bit input with valid/ready handshake
//   o_cfg_we/addr/data,       config-memory write port, transfer on
//   i_cfg_ready                 o_cfg_we && i_cfg_ready
//   o_done, o_error           sticky status
//   o_frames_wr               writes completed since the last HUNT entry
// -----------------------------------------------------------------------------
module minifpga_cfg_loader
   import minifpga_cfg_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16,
   parameter int CNT_W  = 16
) (
   input  logic              i_clk,
   input  logic              i_resetb,
   input  logic              i_clear,
   input  logic              i_sdi,
   input  logic              i_svalid,
   output logic              o_sready,
   output logic              o_cfg_we,
   output logic [ADDR_W-1:0] o_cfg_addr,
   output logic [DATA_W-1:0] o_cfg_data,
   input  logic              i_cfg_ready,
   output logic              o_done,
   output logic              o_error,
   output logic [CNT_W-1:0]  o_frames_wr
);

   localparam int FRAME_W = ADDR_W + DATA_W;
   localparam int BC_MAX  = (FRAME_W > CNT_W) ? ((FRAME_W > 16) ? FRAME_W : 16)
                                              : ((CNT_W > 16) ? CNT_W : 16);
   localparam int BC_W    = $clog2(BC_MAX);

`ifdef MINIFPGA_CFG_CRC_EN
   localparam state_t AFTER_FRAMES = CRC;
`else
   localparam state_t AFTER_FRAMES = DONE;
`endif

   state_t             r_state, w_state_next;
   logic               w_sready, w_take, w_last_bit, w_pre_hit;
   // Only 15 history bits are needed: the 16th compared bit is the incoming one.
   logic [14:0]        r_pre;
   logic [15:0]        w_pre_next;
   logic [BC_W-1:0]    r_bitcnt;
   logic [CNT_W-1:0]   r_remain;        // header shifter, then frames left
   logic [CNT_W-1:0]   w_cnt_next;
   logic [FRAME_W-2:0] r_frame;
   logic [FRAME_W-1:0] w_frame_next;
   logic [ADDR_W-1:0]  r_addr;
   logic [DATA_W-1:0]  r_data;
   logic               r_we, r_done;
   logic [CNT_W-1:0]   r_frames;

`ifdef MINIFPGA_CFG_CRC_EN
   logic               w_crc_en, w_crc_init, r_error;
   logic [15:0]        w_crc, w_rxcrc_next;
   logic [14:0]        r_rxcrc;

   assign w_rxcrc_next = {r_rxcrc, i_sdi};

   minifpga_crc16 u_crc (
      .i_clk    (i_clk),
      .i_resetb (i_resetb),
      .i_init   (w_crc_init),
      .i_en     (w_crc_en),
      .i_bit_in (i_sdi),
      .o_crc    (w_crc)
   );
`endif

   assign w_take       = i_svalid && w_sready;
   assign w_pre_next   = {r_pre, i_sdi};
   assign w_pre_hit    = (w_pre_next == PREAMBLE);
   assign w_cnt_next   = {r_remain[CNT_W-2:0], i_sdi};
   assign w_frame_next = {r_frame, i_sdi};

   always_comb begin
      case (r_state)
         HDR:     w_last_bit = (r_bitcnt == BC_W'(CNT_W - 1));
         FRAME:   w_last_bit = (r_bitcnt == BC_W'(FRAME_W - 1));
         default: w_last_bit = (r_bitcnt == BC_W'(15));
      endcase
   end

   // FSM: state register
   always_ff @(posedge i_clk or negedge i_resetb) begin
      if (!i_resetb) r_state <= HUNT;
      else           r_state <= w_state_next;
   end

   // FSM: next state (CLEAR overrides everything)
   always_comb begin
      w_state_next = r_state;
      if (i_clear) begin
         w_state_next = HUNT;
      end else begin
         case (r_state)
            HUNT:  if (w_take && w_pre_hit) w_state_next = HDR;
            HDR:   if (w_take && w_last_bit)
                      w_state_next = (w_cnt_next == '0) ? AFTER_FRAMES : FRAME;
            FRAME: if (w_take && w_last_bit) w_state_next = WRITE;
            WRITE: if (i_cfg_ready)
                      w_state_next = (r_remain == CNT_W'(1)) ? AFTER_FRAMES : FRAME;
`ifdef MINIFPGA_CFG_CRC_EN
            CRC:   if (w_take && w_last_bit)
                      w_state_next = (w_rxcrc_next == w_crc) ? DONE : ERR;
`endif
            default: w_state_next = r_state;
         endcase
      end
   end

   // FSM: outputs
   always_comb begin
      w_sready = (r_state != WRITE);
`ifdef MINIFPGA_CFG_CRC_EN
      w_crc_init = (r_state == HUNT) && w_take && w_pre_hit;
      w_crc_en   = w_take && ((r_state == HDR) || (r_state == FRAME));
`endif
   end

   // Datapath
   always_ff @(posedge i_clk or negedge i_resetb) begin
      if (!i_resetb) begin
         r_pre    <= '0;
         r_bitcnt <= '0;
         r_remain <= '0;
         r_frame  <= '0;
         r_addr   <= '0;
         r_data   <= '0;
         r_we     <= 1'b0;
         r_done   <= 1'b0;
         r_frames <= '0;
`ifdef MINIFPGA_CFG_CRC_EN
         r_rxcrc  <= '0;
         r_error  <= 1'b0;
`endif
      end else if (i_clear) begin
         r_pre    <= '0;
         r_bitcnt <= '0;
         r_we     <= 1'b0;
         r_done   <= 1'b0;
         r_frames <= '0;
`ifdef MINIFPGA_CFG_CRC_EN
         r_error  <= 1'b0;
`endif
      end else begin
         case (r_state)
            HUNT: begin
               r_bitcnt <= '0;
               if (w_take) r_pre <= w_pre_next[14:0];
            end
            HDR: if (w_take) begin
               r_remain <= w_cnt_next;
               r_bitcnt <= w_last_bit ? '0 : r_bitcnt + 1'b1;
            end
            FRAME: if (w_take) begin
               r_frame  <= w_frame_next[FRAME_W-2:0];
               r_bitcnt <= w_last_bit ? '0 : r_bitcnt + 1'b1;
               if (w_last_bit) begin
                  r_addr <= w_frame_next[FRAME_W-1 -: ADDR_W];
                  r_data <= w_frame_next[DATA_W-1:0];
                  r_we   <= 1'b1;
               end
            end
            WRITE: if (i_cfg_ready) begin
               r_we     <= 1'b0;
               r_frames <= r_frames + 1'b1;
               r_remain <= r_remain - 1'b1;
            end
`ifdef MINIFPGA_CFG_CRC_EN
            CRC: if (w_take) begin
               r_rxcrc  <= w_rxcrc_next[14:0];
               r_bitcnt <= w_last_bit ? '0 : r_bitcnt + 1'b1;
            end
`endif
            default: ;
         endcase
         // Terminal states are only left via CLEAR/reset, so status tracks entry.
         r_done <= (w_state_next == DONE);
`ifdef MINIFPGA_CFG_CRC_EN
         r_error <= (w_state_next == ERR);
`endif
      end
   end

   assign o_sready    = w_sready;
   assign o_cfg_we    = r_we;
   assign o_cfg_addr  = r_addr;
   assign o_cfg_data  = r_data;
   assign o_done      = r_done;
   assign o_frames_wr = r_frames;
`ifdef MINIFPGA_CFG_CRC_EN
   assign o_error     = r_error;
`else
   assign o_error     = 1'b0;
`endif

endmodule

// File: tb/tb_minifpga_cfg_loader.sv
// -----------------------------------------------------------------------------
// tb_minifpga_cfg_loader
// Self-checking bench for minifpga_cfg_loader. Bitstreams are assembled from
// frame lists, the CRC is computed from its textbook serial definition, and
// observed config-memory transfers are compared with the intended writes.
// Honours MINIFPGA_CFG_CRC_EN for the expected DONE/ERROR outcome.
// -----------------------------------------------------------------------------
module tb_minifpga_cfg_loader;

`ifdef MINIFPGA_CFG_CRC_EN
   localparam bit CRC_ON = 1'b1;
`else
   localparam bit CRC_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        i_resetb, i_clear, i_sdi, i_svalid, i_cfg_ready;
   logic        o_sready, o_cfg_we, o_done, o_error;
   logic [7:0]  o_cfg_addr;
   logic [15:0] o_cfg_data, o_frames_wr;

   always #5 clk = ~clk;

   minifpga_cfg_loader #(.ADDR_W(8), .DATA_W(16), .CNT_W(16)) dut (
      .i_clk(clk), .i_resetb(i_resetb), .i_clear(i_clear), .i_sdi(i_sdi),
      .i_svalid(i_svalid), .o_sready(o_sready), .o_cfg_we(o_cfg_we),
      .o_cfg_addr(o_cfg_addr), .o_cfg_data(o_cfg_data), .i_cfg_ready(i_cfg_ready),
      .o_done(o_done), .o_error(o_error), .o_frames_wr(o_frames_wr)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // intended writes and the bitstream carrying them
   logic [7:0]  exp_a[$];
   logic [15:0] exp_d[$];
   bit          bits[$];
   logic [15:0] crc_run;

   // observed transfers
   logic [7:0]  xa[$];
   logic [15:0] xd[$];
   int          runs[$];
   int          run_len, sready_bad, unstable;
   logic        xfer_prev, done_after_xfer;
   logic [7:0]  prev_a;
   logic [15:0] prev_d;
   int          stall_left = 0;

   // CFG_READY source: withholds ready for stall_left cycles of a pending write
   initial begin
      i_cfg_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         if (o_cfg_we && stall_left > 0) begin
            i_cfg_ready = 1'b0;
            stall_left--;
         end else begin
            i_cfg_ready = 1'b1;
         end
      end
   end

   // Write-port monitor, sampled mid-cycle
   always @(negedge clk) begin
      if (xfer_prev) done_after_xfer = o_done;
      xfer_prev = 1'b0;
      if (o_cfg_we) begin
         run_len++;
         if (run_len > 1 && (o_cfg_addr !== prev_a || o_cfg_data !== prev_d)) unstable++;
         if (o_sready) sready_bad++;
         prev_a = o_cfg_addr;
         prev_d = o_cfg_data;
         if (i_cfg_ready) begin
            xa.push_back(o_cfg_addr);
            xd.push_back(o_cfg_data);
            runs.push_back(run_len);
            run_len   = 0;
            xfer_prev = 1'b1;
         end
      end else begin
         run_len = 0;
      end
   end

   task automatic tick(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic start_run();
      i_clear = 1'b1; tick(1); i_clear = 1'b0;
      xa.delete(); xd.delete(); runs.delete();
      exp_a.delete(); exp_d.delete();
      sready_bad = 0; unstable = 0; run_len = 0;
      done_after_xfer = 1'b0; xfer_prev = 1'b0;
      stall_left = 0;
   endtask

   task automatic push_cov(input bit b);
      logic fb;
      bits.push_back(b);
      fb = crc_run[15] ^ b;
      crc_run = {crc_run[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
   endtask

   task automatic build_stream(input bit flip, input bit garbage);
      logic [15:0] w;
      logic [15:0] nn;
      logic [7:0]  a;
      logic [15:0] d;
      bits.delete();
      crc_run = 16'hFFFF;
      if (garbage) begin
         w = 16'h7E7E;
         for (int i = 15; i >= 0; i--) bits.push_back(w[i]);
      end
      w = 16'h7EAA;
      for (int i = 15; i >= 0; i--) bits.push_back(w[i]);
      nn = 16'(exp_a.size());
      for (int i = 15; i >= 0; i--) push_cov(nn[i]);
      for (int k = 0; k < exp_a.size(); k++) begin
         a = exp_a[k];
         d = exp_d[k];
         for (int i = 7; i >= 0; i--)  push_cov(a[i]);
         for (int i = 15; i >= 0; i--) push_cov(d[i]);
      end
      w = crc_run;
      if (flip) w[0] = ~w[0];
      for (int i = 15; i >= 0; i--) bits.push_back(w[i]);
   endtask

   task automatic send_bit(input bit b, input int gap);
      bit ok;
      ok = 1'b0;
      i_svalid = 1'b0;
      tick(gap);
      i_svalid = 1'b1;
      i_sdi = b;
      for (int k = 0; k < 200 && !ok; k++) begin
         if (o_sready) ok = 1'b1;
         tick(1);
      end
      i_svalid = 1'b0;
      if (!ok) begin
         n_cmp++; n_bad++;
         $display("FAIL send_bit: bit not accepted within 200 cycles, sready=%0b required 1", o_sready);
      end
   endtask

   // sends bits[from .. to-1]
   task automatic send_range(input int from, input int to, input int gapmax);
      for (int i = from; i < to; i++)
         send_bit(bits[i], (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0);
   endtask

   task automatic test_reset();
      i_resetb = 1'b0; i_clear = 1'b0; i_sdi = 1'b0; i_svalid = 1'b0;
      tick(3);
      i_resetb = 1'b1;
      tick(1);
      n_cmp++; if (o_cfg_we !== 1'b0)    begin n_bad++; $display("FAIL reset_we: got %0b want 0", o_cfg_we); end
      n_cmp++; if (o_cfg_addr !== 8'h00) begin n_bad++; $display("FAIL reset_addr: got %h want 00", o_cfg_addr); end
      n_cmp++; if (o_cfg_data !== 16'h0) begin n_bad++; $display("FAIL reset_data: got %h want 0000", o_cfg_data); end
      n_cmp++; if (o_done !== 1'b0)      begin n_bad++; $display("FAIL reset_done: got %0b want 0", o_done); end
      n_cmp++; if (o_error !== 1'b0)     begin n_bad++; $display("FAIL reset_error: got %0b want 0", o_error); end
      n_cmp++; if (o_frames_wr !== 16'h0) begin n_bad++; $display("FAIL reset_frames: got %0d want 0", o_frames_wr); end
      n_cmp++; if (o_sready !== 1'b1)    begin n_bad++; $display("FAIL reset_sready: got %0b want 1", o_sready); end
   endtask

   task automatic test_basic();
      start_run();
      exp_a = '{8'h03, 8'h10};
      exp_d = '{16'hBEEF, 16'h1234};
      build_stream(1'b0, 1'b0);
      send_range(0, bits.size(), 0);
      tick(3);
      n_cmp++; if (xa.size() != 2) begin n_bad++; $display("FAIL basic_count: got %0d writes want 2", xa.size()); end
      for (int i = 0; i < xa.size() && i < 2; i++) begin
         n_cmp++; if (xa[i] !== exp_a[i] || xd[i] !== exp_d[i]) begin
            n_bad++; $display("FAIL basic_write%0d: got %h/%h want %h/%h", i, xa[i], xd[i], exp_a[i], exp_d[i]);
         end
      end
      n_cmp++; if (runs.size() > 0 && runs[0] != 1) begin n_bad++; $display("FAIL basic_we_len: got %0d want 1", runs[0]); end
      n_cmp++; if (o_frames_wr !== 16'd2) begin n_bad++; $display("FAIL basic_frames: got %0d want 2", o_frames_wr); end
      n_cmp++; if (o_done !== 1'b1)  begin n_bad++; $display("FAIL basic_done: got %0b want 1", o_done); end
      n_cmp++; if (o_error !== 1'b0) begin n_bad++; $display("FAIL basic_error: got %0b want 0", o_error); end
   endtask

   task automatic test_backpressure();
      start_run();
      stall_left = 5;
      exp_a = '{8'h03, 8'h10};
      exp_d = '{16'hBEEF, 16'h1234};
      build_stream(1'b0, 1'b0);
      send_range(0, bits.size(), 0);
      tick(3);
      n_cmp++; if (runs.size() < 1 || runs[0] != 6) begin n_bad++; $display("FAIL bp_we_len: got %0d want 6", (runs.size() > 0) ? runs[0] : -1); end
      n_cmp++; if (unstable != 0)   begin n_bad++; $display("FAIL bp_stable: got %0d changes want 0", unstable); end
      n_cmp++; if (sready_bad != 0) begin n_bad++; $display("FAIL bp_sready: got %0d cycles high want 0", sready_bad); end
      n_cmp++; if (xa.size() != 2)  begin n_bad++; $display("FAIL bp_count: got %0d writes want 2", xa.size()); end
      for (int i = 0; i < xa.size() && i < 2; i++) begin
         n_cmp++; if (xa[i] !== exp_a[i] || xd[i] !== exp_d[i]) begin
            n_bad++; $display("FAIL bp_write%0d: got %h/%h want %h/%h", i, xa[i], xd[i], exp_a[i], exp_d[i]);
         end
      end
      n_cmp++; if (o_frames_wr !== 16'd2 || o_done !== 1'b1 || o_error !== 1'b0) begin
         n_bad++; $display("FAIL bp_status: got frames=%0d done=%0b err=%0b want 2/1/0", o_frames_wr, o_done, o_error);
      end
   endtask

   task automatic test_crc_error();
      start_run();
      exp_a = '{8'h03, 8'h10};
      exp_d = '{16'hBEEF, 16'h1234};
      build_stream(1'b1, 1'b0);
      send_range(0, bits.size(), 0);
      tick(3);
      n_cmp++; if (xa.size() != 2) begin n_bad++; $display("FAIL crcerr_count: got %0d writes want 2", xa.size()); end
      n_cmp++; if (o_error !== CRC_ON) begin n_bad++; $display("FAIL crcerr_error: got %0b want %0b", o_error, CRC_ON); end
      n_cmp++; if (o_done !== !CRC_ON) begin n_bad++; $display("FAIL crcerr_done: got %0b want %0b", o_done, !CRC_ON); end
      i_clear = 1'b1; tick(1); i_clear = 1'b0;
      n_cmp++; if (o_error !== 1'b0 || o_done !== 1'b0 || o_frames_wr !== 16'h0 || o_sready !== 1'b1) begin
         n_bad++; $display("FAIL crcerr_clear: got err=%0b done=%0b frames=%0d sready=%0b want 0/0/0/1", o_error, o_done, o_frames_wr, o_sready);
      end
   endtask

   task automatic test_hunt_gaps();
      start_run();
      build_stream(1'b0, 1'b1);
      send_range(0, bits.size(), 3);
      tick(3);
      n_cmp++; if (xa.size() != 0) begin n_bad++; $display("FAIL n0_count: got %0d writes want 0", xa.size()); end
      n_cmp++; if (o_done !== 1'b1 || o_error !== 1'b0 || o_frames_wr !== 16'h0) begin
         n_bad++; $display("FAIL n0_status: got done=%0b err=%0b frames=%0d want 1/0/0", o_done, o_error, o_frames_wr);
      end
   endtask

   task automatic test_reset_midframe();
      start_run();
      exp_a = '{8'h21, 8'h42};
      exp_d = '{16'hA5A5, 16'h5A5A};
      build_stream(1'b0, 1'b0);
      send_range(0, 42, 0);
      #2 i_resetb = 1'b0;
      #1;
      n_cmp++; if (o_cfg_we !== 1'b0 || o_frames_wr !== 16'h0 || o_done !== 1'b0 || o_sready !== 1'b1 || o_cfg_addr !== 8'h0 || o_cfg_data !== 16'h0) begin
         n_bad++; $display("FAIL rst_mid_async: got we=%0b frames=%0d done=%0b sready=%0b addr=%h data=%h want reset values", o_cfg_we, o_frames_wr, o_done, o_sready, o_cfg_addr, o_cfg_data);
      end
      @(posedge clk); #1;
      i_resetb = 1'b1;
      tick(1);
      n_cmp++; if (xa.size() != 0) begin n_bad++; $display("FAIL rst_mid_nowrite: got %0d writes want 0", xa.size()); end
      send_range(0, bits.size(), 1);
      tick(3);
      n_cmp++; if (xa.size() != 2 || o_done !== 1'b1 || o_frames_wr !== 16'd2) begin
         n_bad++; $display("FAIL rst_mid_redetect: got writes=%0d done=%0b frames=%0d want 2/1/2", xa.size(), o_done, o_frames_wr);
      end
   endtask

   task automatic test_clear_in_write();
      start_run();
      stall_left = 1000000;
      exp_a = '{8'h77, 8'h88};
      exp_d = '{16'h0F0F, 16'hF0F0};
      build_stream(1'b0, 1'b0);
      send_range(0, 56, 0);
      n_cmp++; if (o_cfg_we !== 1'b1 || o_sready !== 1'b0 || o_cfg_addr !== 8'h77 || o_cfg_data !== 16'h0F0F) begin
         n_bad++; $display("FAIL clr_latency: got we=%0b sready=%0b addr=%h data=%h want 1/0/77/0f0f", o_cfg_we, o_sready, o_cfg_addr, o_cfg_data);
      end
      tick(2);
      i_clear = 1'b1; tick(1); i_clear = 1'b0;
      stall_left = 0;
      n_cmp++; if (o_cfg_we !== 1'b0 || o_frames_wr !== 16'h0 || o_done !== 1'b0 || o_error !== 1'b0 || o_sready !== 1'b1) begin
         n_bad++; $display("FAIL clr_state: got we=%0b frames=%0d done=%0b err=%0b sready=%0b want 0/0/0/0/1", o_cfg_we, o_frames_wr, o_done, o_error, o_sready);
      end
      tick(2);
      n_cmp++; if (xa.size() != 0) begin n_bad++; $display("FAIL clr_nowrite: got %0d writes want 0", xa.size()); end
      send_range(0, bits.size(), 0);
      tick(3);
      n_cmp++; if (xa.size() != 2 || o_done !== 1'b1 || o_frames_wr !== 16'd2) begin
         n_bad++; $display("FAIL clr_redetect: got writes=%0d done=%0b frames=%0d want 2/1/2", xa.size(), o_done, o_frames_wr);
      end
   endtask

   task automatic test_single_frame();
      start_run();
      exp_a = '{8'hFF};
      exp_d = '{16'h0001};
      build_stream(1'b0, 1'b0);
      send_range(0, bits.size(), 0);
      tick(3);
      n_cmp++; if (xa.size() != 1 || (xa.size() == 1 && (xa[0] !== 8'hFF || xd[0] !== 16'h0001))) begin
         n_bad++; $display("FAIL single_write: got %0d writes first=%h/%h want 1 of ff/0001", xa.size(), (xa.size() > 0) ? xa[0] : 8'hxx, (xd.size() > 0) ? xd[0] : 16'hxxxx);
      end
      n_cmp++; if (done_after_xfer !== !CRC_ON) begin n_bad++; $display("FAIL single_done_timing: got %0b want %0b", done_after_xfer, !CRC_ON); end
      n_cmp++; if (o_done !== 1'b1 || o_error !== 1'b0) begin n_bad++; $display("FAIL single_status: got done=%0b err=%0b want 1/0", o_done, o_error); end
   endtask

   task automatic test_random();
      int  n;
      bit  flip;
      for (int it = 0; it < 6; it++) begin
         start_run();
         n = $urandom_range(1, 4);
         for (int k = 0; k < n; k++) begin
            exp_a.push_back(8'($urandom));
            exp_d.push_back(16'($urandom));
         end
         flip = 1'($urandom_range(0, 1));
         stall_left = $urandom_range(0, 3);
         build_stream(flip, 1'b0);
         send_range(0, bits.size(), 2);
         tick(3);
         n_cmp++; if (xa.size() != n) begin n_bad++; $display("FAIL rand%0d_count: got %0d writes want %0d", it, xa.size(), n); end
         for (int i = 0; i < xa.size() && i < n; i++) begin
            n_cmp++; if (xa[i] !== exp_a[i] || xd[i] !== exp_d[i]) begin
               n_bad++; $display("FAIL rand%0d_write%0d: got %h/%h want %h/%h", it, i, xa[i], xd[i], exp_a[i], exp_d[i]);
            end
         end
         n_cmp++; if (o_frames_wr !== 16'(n) || o_done !== (!CRC_ON || !flip) || o_error !== (CRC_ON && flip)) begin
            n_bad++; $display("FAIL rand%0d_status: got frames=%0d done=%0b err=%0b want %0d/%0b/%0b", it, o_frames_wr, o_done, o_error, n, (!CRC_ON || !flip), (CRC_ON && flip));
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_crc_error();
      test_hunt_gaps();
      test_reset_midframe();
      test_clear_in_write();
      test_single_frame();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
